// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM state encoding,
// error codes reported on err_code, and a helper that identifies the states
// in which a frame is being received.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // A frame is in flight (bytes are accepted) only in these four states.
   function automatic logic is_loading(input state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted stream bytes into little-endian 32-bit words. The first
// three bytes of a word are kept in a shift register; the fourth completes the
// word, which is presented combinationally together with word_valid so the
// owner can register it into the write port on the following edge.
module loader_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_idx;
   logic [23:0] partial;

   assign word_valid = byte_en && (byte_idx == 2'd3);
   assign word       = {byte_in, partial};

   // Shift each accepted byte in from the top so the oldest byte ends up lowest.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         byte_idx <= 2'd0;
         partial  <= 24'd0;
      end else if (byte_en) begin
         byte_idx <= byte_idx + 2'd1;
         partial  <= {byte_in, partial[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the instruction memory. Receives a framed byte stream
// (length, data words, XOR checksum), writes the words from address 0 and
// releases the core from reset only after a good checksum.
// Optional build macro IMEM_LOADER_TIMEOUT_EN adds an inter-byte idle timeout
// that aborts a stalled load with err_code 11.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic [1:0]        err_code
);

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

   if (ADDR_W < 1 || ADDR_W > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("imem_loader: ADDR_W must be 1..16 and TIMEOUT_CYCLES 1..65535");
   end

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  err_nxt;
   logic [15:0] len;
   logic [15:0] byte_len;
   logic [16:0] word_cnt;
   logic [7:0]  csum;
   logic        accept;
   logic        restart;
   logic        pk_valid;
   logic [31:0] pk_word;

   assign accept  = in_valid && in_ready;
   assign restart = start && !is_loading(state);

   loader_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (restart),
      .byte_en    (accept && (state == DATA)),
      .byte_in    (in_data),
      .word_valid (pk_valid),
      .word       (pk_word)
   );

`ifdef IMEM_LOADER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] idle_cnt;

   // Count cycles without an accepted byte while a frame is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= 16'd0;
      end else if (restart || accept || !is_loading(state)) begin
         idle_cnt <= 16'd0;
      end else begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end
`endif

   // Next-state and error-code decision for the frame parser.
   always_comb begin
      state_nxt = state;
      err_nxt   = err_code;
      byte_len  = {in_data, len[7:0]};
      case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_nxt = LEN_LO;
               err_nxt   = ERR_NONE;
            end
         end
         LEN_LO: begin
            if (accept) state_nxt = LEN_HI;
         end
         LEN_HI: begin
            if (accept) begin
               if ({1'b0, byte_len} > MAX_WORDS) begin
                  state_nxt = ERR;
                  err_nxt   = ERR_LEN;
               end else if (byte_len == 16'd0) begin
                  state_nxt = CSUM;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (pk_valid && ((word_cnt + 17'd1) == {1'b0, len})) state_nxt = CSUM;
         end
         CSUM: begin
            if (accept) begin
               if (in_data == csum) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ERR;
                  err_nxt   = ERR_CSUM;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
      if (is_loading(state) && !accept && (idle_cnt == TIMEOUT_LIMIT)) begin
         state_nxt = ERR;
         err_nxt   = ERR_TIMEOUT;
      end
`endif
   end

   // State register, registered outputs, write port, length and checksum capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= 32'd0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
         err_code   <= ERR_NONE;
         len        <= 16'd0;
         word_cnt   <= 17'd0;
         csum       <= 8'd0;
      end else begin
         state    <= state_nxt;
         err_code <= err_nxt;
         in_ready <= is_loading(state_nxt);
         done     <= (state_nxt == DONE);
         core_rst <= (state_nxt != DONE);
         imem_we  <= pk_valid;
         if (pk_valid) begin
            imem_waddr <= word_cnt[ADDR_W-1:0];
            imem_wdata <= pk_word;
            word_cnt   <= word_cnt + 17'd1;
         end
         if (restart) begin
            len      <= 16'd0;
            word_cnt <= 17'd0;
            csum     <= 8'd0;
         end else if (accept) begin
            case (state)
               LEN_LO:  len[7:0]  <= in_data;
               LEN_HI:  len[15:8] <= in_data;
               DATA:    csum      <= csum ^ in_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the boot flow plus
// randomized frames checked against a frame-level reference model.
// Build with IMEM_LOADER_TIMEOUT_EN defined to exercise the idle timeout.
module tb_imem_loader;

   typedef logic [7:0]  byte_q_t [$];
   typedef logic [41:0] wr_t;

   localparam int ADDR_W    = 10;
   localparam int BYTE_WAIT = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic [1:0]        err_code;

   int   checks   = 0;
   int   failures = 0;
   wr_t  wr_q [$];
   wr_t  exp_wr [$];
   logic [1:0] exp_err;
   bit   exp_done;
   int   exp_acc;
   bit   we_prev = 1'b0;
   int   wide_cnt = 0;

   imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .done       (done),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   // Record every write strobe and flag strobes wider than one cycle.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_q.push_back({imem_waddr, imem_wdata});
         if (we_prev) wide_cnt++;
      end
      we_prev = imem_we;
   end

   // Frame-level model: parse the byte list and predict writes and outcome.
   function automatic void model_frame(input byte_q_t f);
      int n;
      logic [7:0]  x;
      logic [31:0] w32;
      exp_wr.delete();
      n = int'(f[0]) + 256 * int'(f[1]);
      if (n > (1 << ADDR_W)) begin
         exp_err = 2'b01; exp_done = 1'b0; exp_acc = 2;
         return;
      end
      x = 8'd0;
      for (int w = 0; w < n; w++) begin
         w32 = {f[2+4*w+3], f[2+4*w+2], f[2+4*w+1], f[2+4*w]};
         x = x ^ f[2+4*w] ^ f[2+4*w+1] ^ f[2+4*w+2] ^ f[2+4*w+3];
         exp_wr.push_back({w[ADDR_W-1:0], w32});
      end
      exp_acc = 2 + 4 * n + 1;
      if (f[2+4*n] == x) begin
         exp_err = 2'b00; exp_done = 1'b1;
      end else begin
         exp_err = 2'b10; exp_done = 1'b0;
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < BYTE_WAIT; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Drives one complete frame; optional idle gaps and a stray start pulse.
   task automatic applyStimulus(input byte_q_t f, input bit gaps, input int start_at, output int n_acc);
      bit ok;
      wr_q.delete();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      n_acc = 0;
      for (int i = 0; i < f.size(); i++) begin
         send_byte(f[i], ok);
         if (!ok) break;
         n_acc++;
         if (gaps) begin
            start = (i == start_at);
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (imem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got %b want 0", imem_we); end
      checks++; if (imem_waddr !== '0) begin failures++; $display("[TB] FAIL reset_waddr got %0h want 0", imem_waddr); end
      checks++; if (imem_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata got %0h want 0", imem_wdata); end
      checks++; if (core_rst !== 1'b1) begin failures++; $display("[TB] FAIL reset_core_rst got %b want 1", core_rst); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++; if (err_code !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got %b want 00", err_code); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_in_ready got %b want 0", in_ready); end
   endtask

   task automatic test_normal(input bit gaps);
      byte_q_t f;
      int n_acc;
      f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
      applyStimulus(f, gaps, gaps ? 3 : -1, n_acc);
      checks++; if (n_acc != 11) begin failures++; $display("[TB] FAIL normal_accepts gaps=%0d got %0d want 11", gaps, n_acc); end
      checks++;
      if (wr_q.size() != 2) begin
         failures++; $display("[TB] FAIL normal_write_count gaps=%0d got %0d want 2", gaps, wr_q.size());
      end else if (wr_q[0] !== {10'd0, 32'h00100513} || wr_q[1] !== {10'd1, 32'h00200593}) begin
         failures++; $display("[TB] FAIL normal_writes got %0h,%0h want %0h,%0h", wr_q[0], wr_q[1], {10'd0, 32'h00100513}, {10'd1, 32'h00200593});
      end
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL normal_done got %b want 1", done); end
      checks++; if (core_rst !== 1'b0) begin failures++; $display("[TB] FAIL normal_core_rst got %b want 0", core_rst); end
      checks++; if (err_code !== 2'b00) begin failures++; $display("[TB] FAIL normal_err got %b want 00", err_code); end
      checks++; if (wide_cnt != 0) begin failures++; $display("[TB] FAIL normal_we_width got %0d wide pulses want 0", wide_cnt); end
   endtask

   task automatic test_csum_mismatch();
      byte_q_t f;
      int n_acc;
      f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
      applyStimulus(f, 1'b0, -1, n_acc);
      checks++; if (wr_q.size() != 2) begin failures++; $display("[TB] FAIL csum_write_count got %0d want 2", wr_q.size()); end
      checks++; if (err_code !== 2'b10) begin failures++; $display("[TB] FAIL csum_err got %b want 10", err_code); end
      checks++; if (done !== 1'b0 || core_rst !== 1'b1 || in_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL csum_status got done=%b core_rst=%b in_ready=%b want 0 1 0", done, core_rst, in_ready);
      end
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      checks++; if (err_code !== 2'b00 || in_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL err_restart got err=%b in_ready=%b want 00 1", err_code, in_ready);
      end
      pulse_reset();
   endtask

   task automatic test_empty();
      bit ok;
      wr_q.delete();
      start = 1'b1; in_valid = 1'b1; in_data = 8'h05;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL empty_enter got in_ready=%b want 1", in_ready); end
      send_byte(8'h00, ok);
      send_byte(8'h00, ok);
      send_byte(8'h00, ok);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (done !== 1'b1 || err_code !== 2'b00) begin failures++; $display("[TB] FAIL empty_done got done=%b err=%b want 1 00", done, err_code); end
      checks++; if (wr_q.size() != 0) begin failures++; $display("[TB] FAIL empty_writes got %0d want 0", wr_q.size()); end
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      checks++; if (core_rst !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL done_restart got core_rst=%b done=%b in_ready=%b want 1 0 1", core_rst, done, in_ready);
      end
      pulse_reset();
   endtask

   task automatic test_len_overflow();
      bit ok;
      wr_q.delete();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      send_byte(8'h01, ok);
      send_byte(8'h04, ok);
      checks++; if (err_code !== 2'b01 || in_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL len_err got err=%b in_ready=%b want 01 0", err_code, in_ready);
      end
      send_byte(8'hAA, ok);
      checks++; if (ok !== 1'b0) begin failures++; $display("[TB] FAIL len_after_accept got %b want 0", ok); end
      checks++; if (wr_q.size() != 0) begin failures++; $display("[TB] FAIL len_writes got %0d want 0", wr_q.size()); end
      pulse_reset();
   endtask

   task automatic test_reset_mid_load();
      byte_q_t f;
      bit ok;
      f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
      wr_q.delete();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < f.size(); i++) send_byte(f[i], ok);
      pulse_reset();
      checks++; if (in_ready !== 1'b0 || core_rst !== 1'b1 || done !== 1'b0 || err_code !== 2'b00 || imem_we !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_state got rdy=%b crst=%b done=%b err=%b we=%b want 0 1 0 00 0", in_ready, core_rst, done, err_code, imem_we);
      end
      in_valid = 1'b1; in_data = 8'h20;
      repeat (8) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++; if (wr_q.size() != 1 || wr_q[0] !== {10'd0, 32'h00100513}) begin
         failures++; $display("[TB] FAIL midrst_writes got count=%0d want 1 (word0 only)", wr_q.size());
      end
   endtask

   task automatic test_timeout();
      bit ok;
      pulse_reset();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      send_byte(8'h02, ok); send_byte(8'h00, ok);
      send_byte(8'h13, ok); send_byte(8'h05, ok);
      repeat (12) @(posedge clk);
      #1;
      checks++; if (err_code !== 2'b00 || in_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL timeout_early got err=%b in_ready=%b want 00 1", err_code, in_ready);
      end
      repeat (8) @(posedge clk);
      #1;
`ifdef IMEM_LOADER_TIMEOUT_EN
      checks++; if (err_code !== 2'b11 || in_ready !== 1'b0 || core_rst !== 1'b1) begin
         failures++; $display("[TB] FAIL timeout_err got err=%b in_ready=%b core_rst=%b want 11 0 1", err_code, in_ready, core_rst);
      end
`else
      checks++; if (err_code !== 2'b00 || in_ready !== 1'b1 || done !== 1'b0) begin
         failures++; $display("[TB] FAIL timeout_off got err=%b in_ready=%b done=%b want 00 1 0", err_code, in_ready, done);
      end
`endif
      pulse_reset();
   endtask

   task automatic test_random();
      byte_q_t f;
      int n, n_acc;
      logic [7:0] x;
      for (int iter = 0; iter < 10; iter++) begin
         f.delete();
         x = 8'd0;
         if (iter == 7) n = $urandom_range(1025, 1100);
         else n = $urandom_range(0, 5);
         f.push_back(8'(n));
         f.push_back(8'(n >> 8));
         if (n <= 1024) begin
            for (int k = 0; k < 4 * n; k++) begin
               f.push_back(8'($urandom));
               x = x ^ f[f.size()-1];
            end
            if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
            f.push_back(x);
         end else begin
            f.push_back(8'($urandom));
         end
         model_frame(f);
         applyStimulus(f, 1'($urandom_range(0, 1)), -1, n_acc);
         checks++; if (n_acc != exp_acc) begin failures++; $display("[TB] FAIL rand_accepts iter=%0d got %0d want %0d", iter, n_acc, exp_acc); end
         checks++;
         if (wr_q.size() != exp_wr.size()) begin
            failures++; $display("[TB] FAIL rand_write_count iter=%0d got %0d want %0d", iter, wr_q.size(), exp_wr.size());
         end else begin
            for (int k = 0; k < exp_wr.size(); k++) begin
               if (wr_q[k] !== exp_wr[k]) begin
                  failures++; $display("[TB] FAIL rand_write iter=%0d idx=%0d got %0h want %0h", iter, k, wr_q[k], exp_wr[k]);
                  break;
               end
            end
         end
         checks++; if (err_code !== exp_err || done !== exp_done || core_rst !== !exp_done) begin
            failures++; $display("[TB] FAIL rand_status iter=%0d got err=%b done=%b crst=%b want %b %b %b", iter, err_code, done, core_rst, exp_err, exp_done, !exp_done);
         end
      end
      checks++; if (wide_cnt != 0) begin failures++; $display("[TB] FAIL rand_we_width got %0d wide pulses want 0", wide_cnt); end
   endtask

   initial begin
      test_reset();
      test_normal(1'b0);
      test_csum_mismatch();
      test_empty();
      test_len_overflow();
      test_normal(1'b1);
      pulse_reset();
      test_reset_mid_load();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
